// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI peripheral: FSM state encoding and
// the mode decode that picks which SCLK edge samples MOSI.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_peripheral_param_if.sv
// Word-level receive/transmit handshake between the SPI peripheral and the
// command front end.
interface spi_peripheral_param_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;

  modport slave (
    output rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun,
    input  rx_ready, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin; all stages reset to
// RST_VAL so the pin's idle level is seen from the first cycle.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the pin value through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral_param.sv
// Full-duplex oversampled SPI slave, any CPOL/CPHA, DATA_W-bit words.
// Define SPI_LSB_FIRST_EN to shift both directions LSB first (default MSB first).
module spi_peripheral_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 sclk,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 busy,
  spi_peripheral_param_if.slave bus
);

`ifdef SPI_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  localparam bit              SampleRise = sample_on_rise(CPOL, CPHA);
  localparam int              CW         = $clog2(DATA_W);
  localparam logic [CW-1:0]   LastCnt    = CW'(DATA_W - 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LsbFirst ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
    return LsbFirst ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w, input logic b);
    return LsbFirst ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  logic ss_s, sclk_s, mosi_s;
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d_i(ss_n), .q_o(ss_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

  spi_state_e        state_q, state_d;
  logic              sclk_prev_q;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ovr_q, ovr_d;
  logic              und_q, und_d;
  logic              busy_q;

  logic rise_s, fall_s, sample_s, shift_s;
  logic tx_wr_s, load_s, do_sample_s, do_shift_s, word_done_s;
  logic [DATA_W-1:0] load_word_s, rx_next_s;

  assign rise_s      = sclk_s & ~sclk_prev_q;
  assign fall_s      = ~sclk_s & sclk_prev_q;
  assign sample_s    = SampleRise ? rise_s : fall_s;
  assign shift_s     = SampleRise ? fall_s : rise_s;
  assign tx_wr_s     = bus.tx_valid & tx_ready_q;
  assign load_s      = (state_q == LOAD);
  // A write landing in the LOAD cycle bypasses the holding register.
  assign load_word_s = tx_wr_s ? bus.tx_data : (tx_ready_q ? {DATA_W{1'b0}} : hold_q);
  assign do_sample_s = (state_q == SHIFT) & ~ss_s & sample_s;
  // With CPHA=0 the first bit is already on miso, so the shift edge before the first sample is skipped.
  assign do_shift_s  = (state_q == SHIFT) & ~ss_s & shift_s & (CPHA | (cnt_q != {CW{1'b0}}));
  assign word_done_s = do_sample_s & (cnt_q == LastCnt);
  assign rx_next_s   = rx_insert(rx_sh_q, mosi_s);

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    if (ss_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = LOAD;
        LOAD:    state_d = SHIFT;
        SHIFT:   state_d = (sample_s && (cnt_q == LastCnt)) ? LOAD : SHIFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state: holding register, shifters, bit counter, rx handshake.
  always_comb begin
    miso_d     = miso_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = 1'b0;
    und_d      = 1'b0;

    if (load_s) begin
      tx_ready_d = 1'b1;
      und_d      = tx_ready_q & ~tx_wr_s;
      cnt_d      = {CW{1'b0}};
      if (CPHA) begin
        tx_sh_d = load_word_s;
      end else begin
        tx_sh_d = tx_advance(load_word_s);
        miso_d  = first_bit(load_word_s);
      end
    end else if (tx_wr_s) begin
      hold_d     = bus.tx_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_d = hold_q;
    end

    if (do_shift_s) begin
      miso_d  = first_bit(tx_sh_q);
      tx_sh_d = tx_advance(tx_sh_q);
    end else begin
      tx_sh_d = tx_sh_d;
    end

    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    if (do_sample_s) begin
      rx_sh_d = rx_next_s;
      cnt_d   = cnt_q + CW'(1);
      if (word_done_s) begin
        rx_data_d  = rx_next_s;
        rx_valid_d = 1'b1;
        ovr_d      = rx_valid_q & ~bus.rx_ready;
      end else begin
        rx_data_d = rx_data_q;
      end
    end else begin
      rx_sh_d = rx_sh_q;
    end

    // Deselect abandons any partial word and parks miso low.
    if (ss_s) begin
      miso_d = 1'b0;
      cnt_d  = {CW{1'b0}};
    end else begin
      miso_d = miso_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= CPOL;
      miso_q      <= 1'b0;
      tx_sh_q     <= {DATA_W{1'b0}};
      rx_sh_q     <= {DATA_W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      tx_ready_q  <= 1'b1;
      rx_data_q   <= {DATA_W{1'b0}};
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      miso_q      <= miso_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign miso            = miso_q;
  assign busy            = busy_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_underrun = und_q;

endmodule

// File: tb/tb_spi_peripheral_param.sv
// Directed bench: one DUT per SPI mode, driven by a bit-banged master at a
// half-period of H clk cycles.
module tb_spi_peripheral_param;

  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       ss_n_a [4];
  logic       sclk_a [4];
  logic       mosi_a [4];
  logic       miso_a [4];
  logic       busy_a [4];
  logic [7:0] rx_data_a [4];
  logic       rx_valid_a [4];
  logic       rx_ready_a [4];
  logic       ovr_a [4];
  logic [7:0] tx_data_a [4];
  logic       tx_valid_a [4];
  logic       tx_ready_a [4];
  logic       und_a [4];

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt [4];
  int und_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit Pol = (g >= 2);
    localparam bit Pha = ((g % 2) == 1);
    spi_peripheral_param_if #(.DATA_W(8)) bus ();
    assign bus.rx_ready  = rx_ready_a[g];
    assign bus.tx_data   = tx_data_a[g];
    assign bus.tx_valid  = tx_valid_a[g];
    assign rx_data_a[g]  = bus.rx_data;
    assign rx_valid_a[g] = bus.rx_valid;
    assign ovr_a[g]      = bus.rx_overrun;
    assign tx_ready_a[g] = bus.tx_ready;
    assign und_a[g]      = bus.tx_underrun;
    spi_peripheral_param #(.DATA_W(8), .SYNC_STAGES(2), .CPOL(Pol), .CPHA(Pha)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ss_n (ss_n_a[g]),
      .sclk (sclk_a[g]),
      .mosi (mosi_a[g]),
      .miso (miso_a[g]),
      .busy (busy_a[g]),
      .bus  (bus.slave)
    );
  end

  // Count one-cycle pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ovr_a[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (und_a[i]) und_cnt[i] <= und_cnt[i] + 1;
    end
  end

  typedef struct {
    int         mode;
    bit         pre;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input int m, input logic [7:0] d);
    int k;
    k = 0;
    while (!tx_ready_a[m] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("m%0d_tx_ready_before_push", m), 32'(tx_ready_a[m]), 32'd1);
    tx_data_a[m]  = d;
    tx_valid_a[m] = 1'b1;
    @(negedge clk);
    tx_valid_a[m] = 1'b0;
    chk($sformatf("m%0d_tx_ready_after_push", m), 32'(tx_ready_a[m]), 32'd0);
  endtask

  task automatic rx_consume(input int m);
    rx_ready_a[m] = 1'b1;
    @(negedge clk);
    rx_ready_a[m] = 1'b0;
    chk($sformatf("m%0d_rx_valid_after_consume", m), 32'(rx_valid_a[m]), 32'd0);
  endtask

  // Master side of one word; und_d is the underrun pulse count seen by the first bit.
  task automatic xfer(input int m, input logic [7:0] mo, input int nbits, input bit keep_low,
                      output logic [7:0] mi, output int und_d);
    logic cpol, cpha;
    int   und0;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    und0 = und_cnt[m];
    mi   = 8'h00;
    ss_n_a[m] = 1'b0;
    if (!cpha) mosi_a[m] = mo[7];
    wait_clk(H);
    und_d = und_cnt[m] - und0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mi = {mi[6:0], miso_a[m]};
        sclk_a[m] = ~cpol;
      end else begin
        sclk_a[m] = ~cpol;
        mosi_a[m] = mo[7-i];
      end
      wait_clk(H);
      if (!cpha) begin
        sclk_a[m] = cpol;
        if (i < nbits - 1) mosi_a[m] = mo[6-i];
      end else begin
        mi = {mi[6:0], miso_a[m]};
        sclk_a[m] = cpol;
      end
      wait_clk(H);
    end
    if (!keep_low) begin
      ss_n_a[m] = 1'b1;
      wait_clk(2 * H);
    end
  endtask

  initial begin
    logic [7:0] mi;
    int         ud;
    int         ovr0;

    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      ss_n_a[m]     = 1'b1;
      sclk_a[m]     = (m >= 2);
      mosi_a[m]     = 1'b0;
      rx_ready_a[m] = 1'b0;
      tx_valid_a[m] = 1'b0;
      tx_data_a[m]  = 8'h00;
    end

    vecs[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};
    vecs[2] = '{2, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};
    vecs[3] = '{3, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};
    vecs[4] = '{1, 1'b1, 8'h7E, 8'h81, 8'h7E, 8'h81, 0};
    vecs[5] = '{2, 1'b1, 8'h7E, 8'h81, 8'h7E, 8'h81, 0};
    vecs[6] = '{3, 1'b1, 8'h7E, 8'h81, 8'h7E, 8'h81, 0};
    vecs[7] = '{0, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A, 1};

    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_reset_miso", m),     32'(miso_a[m]),     32'd0);
      chk($sformatf("m%0d_reset_rx_valid", m), 32'(rx_valid_a[m]), 32'd0);
      chk($sformatf("m%0d_reset_rx_data", m),  32'(rx_data_a[m]),  32'd0);
      chk($sformatf("m%0d_reset_tx_ready", m), 32'(tx_ready_a[m]), 32'd1);
      chk($sformatf("m%0d_reset_busy", m),     32'(busy_a[m]),     32'd0);
    end

    for (int v = 0; v < 8; v++) begin
      int m;
      m = vecs[v].mode;
      if (vecs[v].pre) tx_push(m, vecs[v].tx);
      xfer(m, vecs[v].mo, 8, 1'b0, mi, ud);
      chk($sformatf("v%0d_master_rx", v), 32'(mi),            32'(vecs[v].exp_mi));
      chk($sformatf("v%0d_rx_data", v),   32'(rx_data_a[m]),  32'(vecs[v].exp_rx));
      chk($sformatf("v%0d_rx_valid", v),  32'(rx_valid_a[m]), 32'd1);
      chk($sformatf("v%0d_underrun", v),  32'(ud),            32'(vecs[v].exp_und));
      chk($sformatf("v%0d_busy_idle", v), 32'(busy_a[m]),     32'd0);
      rx_consume(m);
    end

    // Back-to-back words with ss_n held low and nobody reading.
    ovr0 = ovr_cnt[0];
    xfer(0, 8'h11, 8, 1'b1, mi, ud);
    chk("b2b_first_word", 32'(rx_data_a[0]), 32'h11);
    chk("b2b_busy_mid", 32'(busy_a[0]), 32'd1);
    xfer(0, 8'h22, 8, 1'b0, mi, ud);
    chk("b2b_rx_data", 32'(rx_data_a[0]), 32'h22);
    chk("b2b_rx_valid", 32'(rx_valid_a[0]), 32'd1);
    chk("b2b_overrun_pulses", 32'(ovr_cnt[0] - ovr0), 32'd1);
    rx_consume(0);

    // Aborted word after 5 bits, then a full frame.
    xfer(0, 8'hFF, 5, 1'b0, mi, ud);
    chk("partial_no_rx_valid", 32'(rx_valid_a[0]), 32'd0);
    chk("partial_miso_low", 32'(miso_a[0]), 32'd0);
    tx_push(0, 8'h3A);
    xfer(0, 8'hC3, 8, 1'b0, mi, ud);
    chk("after_partial_rx_data", 32'(rx_data_a[0]), 32'hC3);
    chk("after_partial_rx_valid", 32'(rx_valid_a[0]), 32'd1);
    chk("after_partial_master_rx", 32'(mi), 32'h3A);

    // Reset in the middle of a frame, with rx_valid high and the holding register full.
    ss_n_a[0] = 1'b0;
    mosi_a[0] = 1'b1;
    wait_clk(H);
    tx_push(0, 8'h55);
    for (int i = 0; i < 3; i++) begin
      sclk_a[0] = 1'b1;
      wait_clk(H);
      sclk_a[0] = 1'b0;
      wait_clk(H);
    end
    chk("pre_reset_busy", 32'(busy_a[0]), 32'd1);
    chk("pre_reset_tx_ready", 32'(tx_ready_a[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_miso", 32'(miso_a[0]), 32'd0);
    chk("midreset_rx_data", 32'(rx_data_a[0]), 32'd0);
    chk("midreset_rx_valid", 32'(rx_valid_a[0]), 32'd0);
    chk("midreset_tx_ready", 32'(tx_ready_a[0]), 32'd1);
    chk("midreset_busy", 32'(busy_a[0]), 32'd0);
    chk("midreset_overrun", 32'(ovr_a[0]), 32'd0);
    chk("midreset_underrun", 32'(und_a[0]), 32'd0);
    ss_n_a[0] = 1'b1;
    mosi_a[0] = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    tx_push(0, 8'h96);
    xfer(0, 8'h69, 8, 1'b0, mi, ud);
    chk("post_reset_master_rx", 32'(mi), 32'h96);
    chk("post_reset_rx_data", 32'(rx_data_a[0]), 32'h69);
    chk("post_reset_rx_valid", 32'(rx_valid_a[0]), 32'd1);
    chk("post_reset_underrun", 32'(ud), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
